// File: rtl/key_bank_loader_pkg.sv
// Shared types and helpers for the key bank loader.
// State encoding, error codes and the byte parity rule.
package dsec_key_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ARMED,
    FAULT
  } state_e;

  localparam logic [1:0] ERR_NONE   = 2'd0;
  localparam logic [1:0] ERR_BUSY   = 2'd1;
  localparam logic [1:0] ERR_PARITY = 2'd2;
  localparam logic [1:0] ERR_ABORT  = 2'd3;

  function automatic logic odd_parity_ok(
    input logic [7:0] b
  );
    return ^b;
  endfunction

endpackage

// File: rtl/key_bank_loader_parity.sv
// Per-byte DES odd-parity check of one key word.
// word_bad is high when any byte has an even popcount.
module byte_parity_chk
  import dsec_key_pkg::*;
#(
  parameter int KEY_W = 64
) (
  input  logic [KEY_W-1:0] data,
  output logic             word_bad
);

  localparam int NB = KEY_W / 8;

  always_comb begin
    word_bad = 1'b0;
    for (int i = 0; i < NB; i++) begin
      if (!odd_parity_ok(data[i*8 +: 8])) begin
        word_bad = 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_bank_loader.sv
// Key-configuration session loader: captures NUM_KEYS keys
// from the input stream and qualifies them for the cipher core.
module key_bank_loader
  import dsec_key_pkg::*;
#(
  parameter int NUM_KEYS   = 3,
  parameter int KEY_W      = 64,
  parameter int PARITY_CHK = 1,
  localparam int IDX_W     = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [KEY_W-1:0]          data_in,
  input  logic                      in_valid,
  input  logic                      key_config,
  input  logic                      busy_in,
  output logic                      rdy,
  output logic [IDX_W-1:0]          key_idx,
  output logic [NUM_KEYS*KEY_W-1:0] keys_flat,
  output logic                      keys_valid,
  output logic                      parity_err,
  output logic [1:0]                err_code
);

  state_e state_q, state_d;
  logic [IDX_W-1:0] key_idx_q, key_idx_d;
  logic [NUM_KEYS-1:0][KEY_W-1:0] keys_q, keys_d;
  logic keys_valid_q, keys_valid_d;
  logic parity_err_q, parity_err_d;
  logic [1:0] err_code_q, err_code_d;
  logic acc_q, acc_d;

  logic word_bad;
  logic start;
  logic data_beat;
  logic last;
  logic bad;

  byte_parity_chk #(
    .KEY_W(KEY_W)
  ) u_par (
    .data    (data_in),
    .word_bad(word_bad)
  );

  assign start     = in_valid & key_config;
  assign data_beat = in_valid & ~key_config;
  assign last      = (key_idx_q == IDX_W'(NUM_KEYS - 1));
  assign bad       = acc_q | word_bad;

  always_comb begin
    state_d      = state_q;
    key_idx_d    = key_idx_q;
    keys_d       = keys_q;
    keys_valid_d = keys_valid_q;
    parity_err_d = parity_err_q;
    err_code_d   = err_code_q;
    acc_d        = acc_q;
    unique case (state_q)
      IDLE, ARMED, FAULT: begin
        if (start) begin
          if (busy_in) begin
            err_code_d = ERR_BUSY;
          end else begin
            state_d      = LOAD;
            key_idx_d    = '0;
            keys_valid_d = 1'b0;
            parity_err_d = 1'b0;
            err_code_d   = ERR_NONE;
            acc_d        = 1'b0;
          end
        end
      end
      LOAD: begin
        // A restart keeps already-written keys in place.
        if (start) begin
          key_idx_d  = '0;
          acc_d      = 1'b0;
          err_code_d = ERR_ABORT;
        end else if (data_beat) begin
          for (int k = 0; k < NUM_KEYS; k++) begin
            if (key_idx_q == IDX_W'(k)) begin
              keys_d[k] = data_in;
            end
          end
          if (last) begin
            key_idx_d = '0;
            if ((PARITY_CHK != 0) && bad) begin
              state_d      = FAULT;
              parity_err_d = 1'b1;
              err_code_d   = ERR_PARITY;
            end else begin
              state_d      = ARMED;
              keys_valid_d = 1'b1;
            end
          end else begin
            key_idx_d = key_idx_q + IDX_W'(1);
            acc_d     = bad;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      key_idx_q    <= '0;
      keys_q       <= '0;
      keys_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      err_code_q   <= ERR_NONE;
      acc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      key_idx_q    <= key_idx_d;
      keys_q       <= keys_d;
      keys_valid_q <= keys_valid_d;
      parity_err_q <= parity_err_d;
      err_code_q   <= err_code_d;
      acc_q        <= acc_d;
    end
  end

  assign rdy        = (state_q == LOAD);
  assign key_idx    = key_idx_q;
  assign keys_flat  = keys_q;
  assign keys_valid = keys_valid_q;
  assign parity_err = parity_err_q;
  assign err_code   = err_code_q;

endmodule

// File: doc/key_bank_loader.md
Name: key_bank_loader

Overview:
- Parametrised successor to the fixed three-key capture logic in the DSEC top level.
- Ingests a key-configuration session from the 64-bit input stream and stores NUM_KEYS keys of KEY_W bits each.
- Optionally checks DES odd parity on every key byte.
- Drives a flat key bus plus a keys_valid qualifier to the encryption core, and reports session and protocol errors to control.

Parameters:
- NUM_KEYS, 3: number of keys per session (1..8).
- KEY_W, 64: key width in bits; must be a multiple of 8 when PARITY_CHK=1.
- PARITY_CHK, 1: 1 enables per-byte odd-parity checking; 0 disables it.
- Derived localparam IDX_W = max(1, clog2(NUM_KEYS)).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; synchronous, active-low.
- data_in  in  KEY_W  input stream word.
- in_valid  in  1  data_in is valid this cycle.
- key_config  in  1  when high with in_valid, the beat is a session-start command.
- busy_in  in  1  datapath has a message in flight; reconfiguring is illegal while high.
- rdy  out  1  high while the block is accepting key words (state LOAD).
- key_idx  out  IDX_W  index of the next key to be written.
- keys_flat  out  NUM_KEYS*KEY_W  key k occupies bits [k*KEY_W +: KEY_W].
- keys_valid  out  1  complete, parity-clean key set is held.
- parity_err  out  1  last completed session had at least one bad byte.
- err_code  out  2  sticky error: 0 none, 1 busy reconfig, 2 parity, 3 aborted session.

Behaviour:
- Reset (rst=0 at a clk edge) forces: state IDLE, all keys 0, key_idx 0, keys_valid 0, parity_err 0, err_code 0, parity accumulator 0.
- Reset takes priority over all other inputs, including mid-LOAD.

States:
- IDLE: no keys.
- LOAD: capturing keys.
- ARMED: keys valid.
- FAULT: parity failure.

Session start (from IDLE, ARMED or FAULT):
- Trigger is in_valid & key_config.
- If busy_in=0: go to LOAD; key_idx←0; keys_valid←0; parity_err←0; err_code←0; accumulator←0. The command beat itself is not stored.
- If busy_in=1: state and keys are unchanged; err_code←1.

LOAD:
- Each in_valid & !key_config beat writes data_in to key[key_idx], increments key_idx, and ORs that word's parity-bad flag into the accumulator.
- The beat with key_idx==NUM_KEYS-1 is the final beat. It wraps key_idx to 0 and selects the next state:
  - bad = accumulator | bad flag of the final word.
  - PARITY_CHK=1 and bad: go to FAULT; parity_err←1; err_code←2.
  - Otherwise: go to ARMED; keys_valid←1.
- keys_valid rises exactly 1 cycle after the last key beat is sampled.
- in_valid & key_config during LOAD restarts the session: key_idx←0, accumulator←0, err_code←3, keys already written are retained. busy_in is not checked here.
- Cycles with in_valid=0 hold all state; there is no timeout.

Other states:
- In IDLE, ARMED and FAULT, in_valid & !key_config beats are message data and are ignored.
- ARMED holds keys_valid=1 until the next session start.
- In FAULT, keys_valid=0. The stored (bad) keys stay visible on keys_flat.

Outputs and encodings:
- rdy = (state==LOAD); purely combinational decode of the state register.
- Parity rule: a byte passes if its popcount is odd. A word is bad if any byte fails.
- Keys are stored even when their parity is bad.
- NUM_KEYS=1: the first data beat after the command completes the session.
- With the default parameters, a session is 4 beats: command, then K1, K2, K3.

Decomposition:
- Shared package dsec_key_pkg contains:
  - state enum {IDLE, LOAD, ARMED, FAULT};
  - err_code constants ERR_NONE, ERR_BUSY, ERR_PARITY, ERR_ABORT;
  - function odd_parity_ok(byte).
- One sub-module, byte_parity_chk (parameter KEY_W): combinational per-byte odd-parity check producing a word-bad flag.
- Key storage and the FSM stay in key_bank_loader.

Test Plan:
1. Defaults; rst low 2 cycles → all outputs 0, rdy 0. Then command beat followed by keys 0x0123456789ABCDEF, 0x23456789ABCDEF01, 0x456789ABCDEF0123 → keys_valid=1 one cycle after the third key; keys_flat slices match; err_code=0.
2. Same session, but K2=0x0000000000000000 → state FAULT; keys_valid=0; parity_err=1; err_code=2; K2 slice reads 0. A new clean session then reaches ARMED and clears parity_err.
3. ARMED, busy_in=1, command beat → err_code=1; keys_valid stays 1; keys unchanged; rdy stays 0.
4. Mid-LOAD after K1, a second command beat → key_idx=0, err_code=3. Three clean keys then → ARMED, with the new values in all slices.
5. Gaps: in_valid low 5 cycles between K1 and K2 → key_idx holds at 1; the session completes normally. A non-command beat in ARMED leaves the keys untouched.
6. rst low mid-LOAD (after K2) → next cycle IDLE, keys 0, keys_valid 0. Also run with NUM_KEYS=1, PARITY_CHK=0: key 0x0 → ARMED in one beat.
